// File: rtl/beamform_pkg.sv
// Shared types for the beamformer sample path: 19-bit samples grouped into 4-lane frames.
// Used by the 1:4 demux and the matching 4:1 serializer on the return path.
package beamform_pkg;

    localparam int SAMPLE_W = 19;
    localparam int LANES    = 4;
    localparam int SLOT_W   = 2;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef sample_t [LANES-1:0] frame_t;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LANES - 1);

    // Lane k of a flat frame bus, lane 0 in the least significant bits.
    function automatic sample_t frame_lane(input frame_t f, input int k);
        return f[k];
    endfunction

endpackage

// File: rtl/demux1to4_stream_if.sv
// Valid/ready stream bundle of configurable width; master drives valid/data,
// slave drives ready.
interface demux1to4_stream_if #(
    parameter int W = 19
);

    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/frame_out_reg.sv
// Valid/ready holding register: loads a word, holds it until accepted, then clears valid.
// can_load tells the producer a load this cycle cannot overwrite an unaccepted word.
module frame_out_reg
    import beamform_pkg::*;
#(
    parameter int W = SAMPLE_W * LANES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         can_load
);

    assign can_load = !out_valid || out_ready;

    // Data is only ever replaced by a load, so it holds its last value while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1to4_stream.sv
// 1:4 stream demux: four consecutive samples become one aligned 4-lane frame.
// Optional stall counter enabled by DEMUX_STALL_CNT_EN.
module demux1to4_stream
    import beamform_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W
`ifdef DEMUX_STALL_CNT_EN
    ,
    parameter int STALL_CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    demux1to4_stream_if.slave  s,
    demux1to4_stream_if.master m,
    output logic [SLOT_W-1:0] slot
`ifdef DEMUX_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    logic [DATA_W-1:0]   lane0;
    logic [DATA_W-1:0]   lane1;
    logic [DATA_W-1:0]   lane2;
    logic                frame_ready;
    logic                accept;
    logic                load;
    logic [4*DATA_W-1:0] load_data;

    // Only the last slot needs the output register free; earlier slots land in capture lanes.
    assign s.ready   = (slot != LAST_SLOT) || frame_ready;
    assign accept    = s.valid && s.ready && !flush;
    assign load      = accept && (slot == LAST_SLOT);
    assign load_data = {s.data, lane2, lane1, lane0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot  <= '0;
            lane0 <= '0;
            lane1 <= '0;
            lane2 <= '0;
        end else if (flush) begin
            slot <= '0;
        end else if (accept) begin
            case (slot)
                2'd0:    lane0 <= s.data;
                2'd1:    lane1 <= s.data;
                2'd2:    lane2 <= s.data;
                default: ;
            endcase
            slot <= slot + 1'b1;
        end
    end

    frame_out_reg #(
        .W (4 * DATA_W)
    ) u_frame_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .out_ready (m.ready),
        .out_valid (m.valid),
        .out_data  (m.data),
        .can_load  (frame_ready)
    );

`ifdef DEMUX_STALL_CNT_EN
    // Saturating; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (s.valid && !s.ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux1to4_stream.sv
// Self-checking bench for demux1to4_stream: scenario tasks plus a cycle model
// whose expected frames are queued on input accept and popped on output accept.
module tb_demux1to4_stream;
    import beamform_pkg::*;

    localparam int DW = SAMPLE_W;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [SLOT_W-1:0] slot;
`ifdef DEMUX_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    demux1to4_stream_if #(.W(DW))     s_if ();
    demux1to4_stream_if #(.W(4 * DW)) m_if ();

    demux1to4_stream dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .s     (s_if),
        .m     (m_if),
        .slot  (slot)
`ifdef DEMUX_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [SLOT_W-1:0] slot_m;
    bit                mv_m;
    frame_t            md_m;
    sample_t           part[$];
    frame_t            expq[$];
    logic [15:0]       stall_m;

    function automatic bit ready_m();
        return (slot_m != 2'd3) || !mv_m || m_if.ready;
    endfunction

    function automatic frame_t mkf(input sample_t a, input sample_t b,
                                   input sample_t c, input sample_t d);
        frame_t f;
        f[0] = a;
        f[1] = b;
        f[2] = c;
        f[3] = d;
        return f;
    endfunction

    // Reference model, updated on the edge from inputs that are stable there.
    always @(posedge clk) begin
        bit     rdy;
        bit     ohs;
        bit     ld;
        frame_t f;
        if (!rst_n) begin
            slot_m  = '0;
            mv_m    = 1'b0;
            md_m    = '0;
            stall_m = '0;
            part.delete();
            expq.delete();
        end else begin
            rdy = ready_m();
            ohs = mv_m && m_if.ready;
            ld  = 1'b0;
            if (s_if.valid && !rdy && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
            if (ohs && expq.size() > 0) void'(expq.pop_front());
            if (flush) begin
                slot_m = '0;
                part.delete();
            end else if (s_if.valid && rdy) begin
                part.push_back(s_if.data);
                if (part.size() == 4) begin
                    f = mkf(part[0], part[1], part[2], part[3]);
                    expq.push_back(f);
                    md_m = f;
                    ld   = 1'b1;
                    part.delete();
                    slot_m = '0;
                end else begin
                    slot_m = slot_m + 2'd1;
                end
            end
            if (ld) mv_m = 1'b1;
            else if (ohs) mv_m = 1'b0;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (m_if.valid !== mv_m) begin
                errors++;
                $display("FAIL mon_m_valid: got %b expected %b at %0t", m_if.valid, mv_m, $time);
            end
            checks++;
            if (slot !== slot_m) begin
                errors++;
                $display("FAIL mon_slot: got %0d expected %0d at %0t", slot, slot_m, $time);
            end
            checks++;
            if (s_if.ready !== ready_m()) begin
                errors++;
                $display("FAIL mon_s_ready: got %b expected %b at %0t", s_if.ready, ready_m(), $time);
            end
            checks++;
            if (m_if.data !== md_m) begin
                errors++;
                $display("FAIL mon_m_data: got %h expected %h at %0t", m_if.data, md_m, $time);
            end
            if (mv_m) begin
                checks++;
                if (expq.size() == 0 || m_if.data !== expq[0]) begin
                    errors++;
                    $display("FAIL sb_frame: got %h expected %h at %0t", m_if.data,
                             (expq.size() > 0) ? expq[0] : '0, $time);
                end
            end
`ifdef DEMUX_STALL_CNT_EN
            checks++;
            if (stall_cnt !== stall_m) begin
                errors++;
                $display("FAIL mon_stall_cnt: got %0d expected %0d at %0t", stall_cnt, stall_m, $time);
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        flush      = 1'b0;
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [DW-1:0] v);
        bit done;
        done       = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = v;
        for (int n = 0; n < 50 && !done; n++) begin
            #2;
            done = s_if.ready;
            tick();
        end
        s_if.valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: sample %h not accepted within 50 cycles", v);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (m_if.valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b expected 0", m_if.valid); end
        checks++;
        if (slot !== 2'd0) begin errors++; $display("FAIL rst_slot: got %0d expected 0", slot); end
        checks++;
        if (m_if.data !== '0) begin errors++; $display("FAIL rst_m_data: got %h expected 0", m_if.data); end
        checks++;
        if (s_if.ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b expected 1", s_if.ready); end
    endtask

    task automatic test_streaming();
        do_reset();
        m_if.ready = 1'b1;
        s_if.valid = 1'b1;
        s_if.data  = 19'h00001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            s_if.data = DW'(i + 1);
            checks++;
            if (s_if.ready !== 1'b1) begin errors++; $display("FAIL stream_s_ready: got %b expected 1 cycle %0d", s_if.ready, i); end
            if (i == 3 || i == 5) begin
                checks++;
                if (m_if.valid !== 1'b0) begin errors++; $display("FAIL stream_m_valid_low: got %b expected 0 cycle %0d", m_if.valid, i); end
            end
            if (i == 4 || i == 8) begin
                checks++;
                if (m_if.valid !== 1'b1) begin errors++; $display("FAIL stream_m_valid: got %b expected 1 cycle %0d", m_if.valid, i); end
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (m_if.data[k*DW +: DW] !== DW'(i - 3 + k)) begin
                        errors++;
                        $display("FAIL stream_lane%0d: got %h expected %h", k, m_if.data[k*DW +: DW], DW'(i - 3 + k));
                    end
                end
            end
        end
        s_if.valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int v = 1; v <= 7; v++) send(DW'(v));
        s_if.valid = 1'b1;
        s_if.data  = 19'd8;
        for (int r = 0; r < 2; r++) begin
            tick();
            checks++;
            if (s_if.ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready: got %b expected 0", s_if.ready); end
            checks++;
            if (slot !== 2'd3) begin errors++; $display("FAIL bp_slot: got %0d expected 3", slot); end
            checks++;
            if (m_if.valid !== 1'b1 || m_if.data !== mkf(1, 2, 3, 4)) begin
                errors++;
                $display("FAIL bp_hold: got %b/%h expected 1/%h", m_if.valid, m_if.data, mkf(1, 2, 3, 4));
            end
        end
        m_if.ready = 1'b1;
        tick();
        m_if.ready = 1'b0;
        s_if.valid = 1'b0;
        checks++;
        if (m_if.valid !== 1'b1 || m_if.data !== mkf(5, 6, 7, 8)) begin
            errors++;
            $display("FAIL bp_passthru: got %b/%h expected 1/%h", m_if.valid, m_if.data, mkf(5, 6, 7, 8));
        end
        m_if.ready = 1'b1;
        tick();
        checks++;
        if (m_if.valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", m_if.valid); end
    endtask

    task automatic test_flush();
        do_reset();
        m_if.ready = 1'b1;
        send(19'h7FFFF);
        send(19'h40000);
        s_if.valid = 1'b1;
        s_if.data  = 19'h11111;
        flush      = 1'b1;
        tick();
        flush      = 1'b0;
        s_if.valid = 1'b0;
        checks++;
        if (slot !== 2'd0) begin errors++; $display("FAIL flush_slot: got %0d expected 0", slot); end
        send(19'hA);
        send(19'hB);
        send(19'hC);
        send(19'hD);
        checks++;
        if (m_if.valid !== 1'b1 || m_if.data !== mkf(19'hA, 19'hB, 19'hC, 19'hD)) begin
            errors++;
            $display("FAIL flush_frame: got %b/%h expected 1/%h", m_if.valid, m_if.data, mkf(19'hA, 19'hB, 19'hC, 19'hD));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int v = 1; v <= 6; v++) send(DW'(v));
        checks++;
        if (m_if.valid !== 1'b1 || slot !== 2'd2) begin
            errors++;
            $display("FAIL mid_setup: got valid=%b slot=%0d expected 1/2", m_if.valid, slot);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (m_if.valid !== 1'b0 || slot !== 2'd0 || m_if.data !== '0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b slot=%0d data=%h expected 0/0/0", m_if.valid, slot, m_if.data);
        end
        m_if.ready = 1'b1;
        for (int v = 9; v <= 12; v++) send(DW'(v));
        checks++;
        if (m_if.valid !== 1'b1 || m_if.data !== mkf(9, 10, 11, 12)) begin
            errors++;
            $display("FAIL mid_frame: got %b/%h expected 1/%h", m_if.valid, m_if.data, mkf(9, 10, 11, 12));
        end
        tick();
    endtask

    task automatic test_idle_gaps();
        do_reset();
        m_if.ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(DW'(i));
            checks++;
            if (slot !== 2'(i % 4)) begin errors++; $display("FAIL gap_slot_hs: got %0d expected %0d", slot, i % 4); end
            if (i == 4) begin
                checks++;
                if (m_if.valid !== 1'b1 || m_if.data !== mkf(1, 2, 3, 4)) begin
                    errors++;
                    $display("FAIL gap_frame: got %b/%h expected 1/%h", m_if.valid, m_if.data, mkf(1, 2, 3, 4));
                end
            end
            tick();
            checks++;
            if (slot !== 2'(i % 4)) begin errors++; $display("FAIL gap_slot_idle: got %0d expected %0d", slot, i % 4); end
        end
        checks++;
        if (m_if.valid !== 1'b0) begin errors++; $display("FAIL gap_drain: got %b expected 0", m_if.valid); end
    endtask

`ifdef DEMUX_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        for (int v = 1; v <= 7; v++) send(DW'(v));
        s_if.valid = 1'b1;
        s_if.data  = 19'd8;
        repeat (10) tick();
        checks++;
        if (stall_cnt !== 16'd10) begin errors++; $display("FAIL stall_10: got %0d expected 10", stall_cnt); end
        repeat (65530) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat: got %h expected ffff", stall_cnt); end
        s_if.valid = 1'b0;
        flush      = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_flush: got %h expected ffff", stall_cnt); end
        m_if.ready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.valid = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b0;
        rst_n      = 1'b0;
        #1;
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_idle_gaps();
`ifdef DEMUX_STALL_CNT_EN
        test_stall_cnt();
`endif
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
